pac_sprite_anim: RTL and testbench



---
 rtl/pac_anim_pkg.sv | 27 ++
 rtl/pac_sprite_anim_frame_timer.sv | 32 +++
 rtl/pac_sprite_anim.sv | 144 ++++++++++++++
 tb/tb_pac_sprite_anim.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pac_anim_pkg.sv
// Shared types and helpers for the Pac-Man sprite animation controller.
package pac_anim_pkg;

  typedef enum logic [1:0] {IDLE, MOVE, DEATH, WON} anim_state_t;
  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } dir_dec_t;

  localparam int SPRITE_CIRCLE = 0;

  // X motion wins over Y; any nonzero magnitude counts as movement.
  function automatic dir_dec_t dir_decode(input logic [9:0] motion_x, input logic [9:0] motion_y);
    dir_dec_t d;
    d.valid = 1'b1;
    d.dir   = DIR_RIGHT;
    if (motion_x[9])              d.dir = DIR_LEFT;
    else if (motion_x != 10'd0)   d.dir = DIR_RIGHT;
    else if (motion_y[9])         d.dir = DIR_UP;
    else if (motion_y != 10'd0)   d.dir = DIR_DOWN;
    else                          d.valid = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/pac_sprite_anim_frame_timer.sv
// Animation frame timer: counts 0..FRAME_TICKS-1, holds while frozen, clears on request.
// tick is the internal frame-boundary event; frame_tick is its registered copy.
module anim_frame_timer #(
  parameter int FRAME_TICKS = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic freeze,
  input  logic clear,
  output logic tick,
  output logic frame_tick
);

  localparam int            CW   = $clog2(FRAME_TICKS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

  logic [CW-1:0] count;

  assign tick = !freeze && !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick;
      if (clear || tick) count <= '0;
      else if (!freeze)  count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/pac_sprite_anim.sv
// Pac-Man sprite animation controller: ping-pong mouth cycling, death sequence, won hold, freeze.
// Optional PAC_HOLD_DIR_EN: a stop keeps facing the last direction with the mouth wide open.
module pac_sprite_anim
  import pac_anim_pkg::*;
#(
  parameter int FRAME_TICKS  = 5_000_000,
  parameter int MOUTH_FRAMES = 3,
  parameter int DEATH_FRAMES = 8,
  parameter int CODE_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        motion_x,
  input  logic [9:0]        motion_y,
  input  logic              won,
  input  logic              die,
  input  logic              freeze,
  output logic [CODE_W-1:0] sprite_code,
  output logic [1:0]        dir,
  output logic              death_done,
  output logic              frame_tick
);

  localparam int                FW         = (MOUTH_FRAMES > 1) ? $clog2(MOUTH_FRAMES) : 1;
  localparam int                DW         = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [FW-1:0]     FRAME_MAX  = FW'(MOUTH_FRAMES - 1);
  localparam logic [DW-1:0]     DEATH_LAST = DW'(DEATH_FRAMES - 1);
  localparam logic [CODE_W-1:0] DEATH_BASE = CODE_W'(1 + 4 * MOUTH_FRAMES);
  localparam logic [CODE_W-1:0] CIRCLE     = CODE_W'(SPRITE_CIRCLE);

  anim_state_t   state;
  dir_t          dir_r;
  logic [FW-1:0] frame, step_frame;
  logic          pp_up, step_up;
  logic [DW-1:0] dframe;
  dir_dec_t      dec;
  logic          tick, start_death;

  function automatic logic [CODE_W-1:0] move_code(input dir_t d, input logic [FW-1:0] f);
    return CODE_W'(1 + int'(d) * MOUTH_FRAMES + int'(f));
  endfunction

  assign dec         = dir_decode(motion_x, motion_y);
  assign start_death = die && (state != DEATH);
  assign dir         = dir_r;

  anim_frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .freeze     (freeze),
    .clear      (start_death),
    .tick       (tick),
    .frame_tick (frame_tick)
  );

  // Ping-pong: turn around at either end of the mouth range.
  always_comb begin
    step_up    = pp_up;
    step_frame = frame;
    if (pp_up && frame == FRAME_MAX) begin
      step_up    = 1'b0;
      step_frame = frame - FW'(1);
    end else if (!pp_up && frame == '0) begin
      step_up    = 1'b1;
      step_frame = frame + FW'(1);
    end else if (pp_up) begin
      step_frame = frame + FW'(1);
    end else begin
      step_frame = frame - FW'(1);
    end
  end

  // sprite_code is loaded alongside the state it describes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      frame       <= '0;
      pp_up       <= 1'b1;
      dframe      <= '0;
      dir_r       <= DIR_RIGHT;
      sprite_code <= CIRCLE;
      death_done  <= 1'b0;
    end else begin
      death_done <= 1'b0;
      if (start_death) begin
        state       <= DEATH;
        dframe      <= '0;
        sprite_code <= DEATH_BASE;
      end else if (won && (state == IDLE || state == MOVE)) begin
        state       <= WON;
        frame       <= '0;
        sprite_code <= CIRCLE;
      end else if (tick) begin
        case (state)
          IDLE: begin
            if (dec.valid) begin
              state       <= MOVE;
              dir_r       <= dec.dir;
              frame       <= FW'(1);
              pp_up       <= 1'b1;
              sprite_code <= move_code(dec.dir, FW'(1));
            end
          end
          MOVE: begin
            if (!dec.valid) begin
`ifdef PAC_HOLD_DIR_EN
              frame       <= FRAME_MAX;
              pp_up       <= 1'b0;
              sprite_code <= move_code(dir_r, FRAME_MAX);
`else
              state       <= IDLE;
              frame       <= '0;
              sprite_code <= CIRCLE;
`endif
            end else begin
              dir_r       <= dec.dir;
              frame       <= step_frame;
              pp_up       <= step_up;
              sprite_code <= move_code(dec.dir, step_frame);
            end
          end
          DEATH: begin
            if (dframe == DEATH_LAST) begin
              state       <= IDLE;
              frame       <= '0;
              dframe      <= '0;
              dir_r       <= DIR_RIGHT;
              death_done  <= 1'b1;
              sprite_code <= CIRCLE;
            end else begin
              dframe      <= dframe + DW'(1);
              sprite_code <= DEATH_BASE + CODE_W'(dframe + DW'(1));
            end
          end
          WON: begin
            if (!won) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pac_sprite_anim.sv
// Self-checking bench for pac_sprite_anim with FRAME_TICKS=4, MOUTH_FRAMES=3, DEATH_FRAMES=8.
module tb_pac_sprite_anim;

  logic       clk;
  logic       reset;
  logic [9:0] motion_x, motion_y;
  logic       won, die, freeze;
  logic [4:0] sprite_code;
  logic [1:0] dir;
  logic       death_done, frame_tick;

  pac_sprite_anim #(
    .FRAME_TICKS(4), .MOUTH_FRAMES(3), .DEATH_FRAMES(8), .CODE_W(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .motion_x    (motion_x),
    .motion_y    (motion_y),
    .won         (won),
    .die         (die),
    .freeze      (freeze),
    .sprite_code (sprite_code),
    .dir         (dir),
    .death_done  (death_done),
    .frame_tick  (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PAC_HOLD_DIR_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    logic signed [9:0] mx;
    logic signed [9:0] my;
    logic              w;
    logic              mid;
    logic              die_mid;
    logic [4:0]        code;
    logic [1:0]        d;
    logic              done;
  } frame_t;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [4:0] cur_code;
  logic [1:0] cur_dir;
  frame_t     move_tbl[$];

  function automatic frame_t fr(input logic signed [9:0] mx, input logic signed [9:0] my,
                                input logic w, input logic mid, input logic die_mid,
                                input logic [4:0] code, input logic [1:0] d, input logic done);
    frame_t f;
    f.mx = mx; f.my = my; f.w = w; f.mid = mid; f.die_mid = die_mid;
    f.code = code; f.d = d; f.done = done;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    #1;
  endtask

  // One animation frame: starts 1ns after a tick edge, ends 1ns after the next tick edge.
  task automatic run_frame(input frame_t r);
    logic [7:0] e;
    exp_q.push_back({r.code, r.d, r.done});
    if (!r.mid) begin
      motion_x = r.mx;
      motion_y = r.my;
    end
    won = r.w;
    for (int c = 1; c <= 4; c++) begin
      clk_cycle();
      if (c < 4) begin
        check("hold_code", sprite_code, cur_code);
        check("hold_dir", dir, cur_dir);
        check("no_tick", frame_tick, 1'b0);
        check("no_done", death_done, 1'b0);
        if (c == 1 && r.die_mid) die = 1'b1;
        if (c == 2) begin
          die = 1'b0;
          if (r.mid) begin
            motion_x = r.mx;
            motion_y = r.my;
          end
        end
      end else begin
        e = exp_q.pop_front();
        check("frame_tick", frame_tick, 1'b1);
        check("tick_code", sprite_code, e[7:3]);
        check("tick_dir", dir, e[2:1]);
        check("tick_done", death_done, e[0]);
        cur_code = e[7:3];
        cur_dir  = e[2:1];
      end
    end
  endtask

  task automatic die_pulse(input logic w);
    die = 1'b1;
    won = w;
    clk_cycle();
    check("die_code", sprite_code, 5'd13);
    check("die_dir", dir, cur_dir);
    die = 1'b0;
    cur_code = 5'd13;
  endtask

  task automatic run_death(input logic w, input logic [1:0] d);
    for (int k = 1; k <= 7; k++)
      run_frame(fr(0, 0, w, 1'b0, (k == 2), 5'(13 + k), d, 1'b0));
    run_frame(fr(0, 0, w, 1'b0, 1'b0, 5'd0, 2'd0, 1'b1));
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    move_tbl.push_back(fr( 1,  0, 0, 0, 0, 5'd2, 2'd0, 0));
    move_tbl.push_back(fr( 1,  0, 0, 0, 0, 5'd3, 2'd0, 0));
    move_tbl.push_back(fr( 1,  0, 0, 0, 0, 5'd2, 2'd0, 0));
    move_tbl.push_back(fr( 1,  0, 0, 0, 0, 5'd1, 2'd0, 0));
    move_tbl.push_back(fr( 1,  0, 0, 0, 0, 5'd2, 2'd0, 0));
    move_tbl.push_back(fr( 1,  0, 0, 0, 0, 5'd3, 2'd0, 0));
    move_tbl.push_back(fr( 0, -5, 0, 1, 0, 5'd8, 2'd2, 0));
    move_tbl.push_back(fr( 0, -5, 0, 0, 0, 5'd7, 2'd2, 0));
    move_tbl.push_back(fr( 0,  0, 0, 0, 0, HOLD ? 5'd9 : 5'd0, 2'd2, 0));
    move_tbl.push_back(fr( 0,  0, 0, 0, 0, HOLD ? 5'd9 : 5'd0, 2'd2, 0));
    move_tbl.push_back(fr(-3,  0, 0, 0, 0, 5'd5, 2'd1, 0));
    move_tbl.push_back(fr( 0,  2, 0, 0, 0, HOLD ? 5'd10 : 5'd12, 2'd3, 0));
    move_tbl.push_back(fr( 7, -1, 0, 0, 0, 5'd2, 2'd0, 0));
    move_tbl.push_back(fr(-1,  1, 0, 0, 0, HOLD ? 5'd6 : 5'd4, 2'd1, 0));
    move_tbl.push_back(fr(-512, 0, 0, 0, 0, 5'd5, 2'd1, 0));
    move_tbl.push_back(fr(511,  0, 0, 0, 0, HOLD ? 5'd1 : 5'd3, 2'd0, 0));

    reset = 1'b0; motion_x = '0; motion_y = '0; won = 1'b0; die = 1'b0; freeze = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_code", sprite_code, 5'd0);
    check("rst_dir", dir, 2'd0);
    check("rst_done", death_done, 1'b0);
    check("rst_tick", frame_tick, 1'b0);
    reset = 1'b1;
    cur_code = 5'd0;
    cur_dir  = 2'd0;

    // Movement, direction changes, stop, priority and extreme magnitudes.
    foreach (move_tbl[i]) run_frame(move_tbl[i]);

    // Death sequence from MOVE, second die ignored mid-sequence.
    die_pulse(1'b0);
    run_death(1'b0, 2'd0);
    run_frame(fr(0, 0, 0, 0, 0, 5'd0, 2'd0, 0));

    // won with die: die wins; held won enters WON after death_done.
    die_pulse(1'b1);
    run_death(1'b1, 2'd0);
    run_frame(fr(1, 0, 1, 0, 0, 5'd0, 2'd0, 0));
    run_frame(fr(1, 0, 0, 0, 0, 5'd0, 2'd0, 0));
    run_frame(fr(1, 0, 0, 0, 0, 5'd2, 2'd0, 0));

    // won acts immediately in MOVE, released WON goes IDLE at the next tick.
    won = 1'b1;
    clk_cycle();
    check("won_immediate", sprite_code, 5'd0);
    won = 1'b0;
    repeat (3) clk_cycle();
    check("won_exit_tick", frame_tick, 1'b1);
    check("won_exit_code", sprite_code, 5'd0);
    cur_code = 5'd0;
    run_frame(fr(1, 0, 0, 0, 0, 5'd2, 2'd0, 0));

    // Freeze in MOVE, then die while frozen stalls the death sequence.
    freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin
      clk_cycle();
      check("freeze_tick", frame_tick, 1'b0);
      check("freeze_code", sprite_code, 5'd2);
    end
    die_pulse(1'b0);
    for (int i = 0; i < 10; i++) begin
      clk_cycle();
      check("freeze_death_tick", frame_tick, 1'b0);
      check("freeze_death_code", sprite_code, 5'd13);
    end
    freeze = 1'b0;
    run_death(1'b0, 2'd0);

    // Reset in the middle of a death sequence.
    run_frame(fr(-1, 0, 0, 0, 0, 5'd5, 2'd1, 0));
    die_pulse(1'b0);
    run_frame(fr(0, 0, 0, 0, 0, 5'd14, 2'd1, 0));
    run_frame(fr(0, 0, 0, 0, 0, 5'd15, 2'd1, 0));
    clk_cycle();
    reset = 1'b0;
    clk_cycle();
    check("mid_rst_code", sprite_code, 5'd0);
    check("mid_rst_dir", dir, 2'd0);
    check("mid_rst_done", death_done, 1'b0);
    check("mid_rst_tick", frame_tick, 1'b0);
    reset = 1'b1;
    cur_code = 5'd0;
    cur_dir  = 2'd0;
    for (int i = 0; i < 6; i++) run_frame(fr(0, 0, 0, 0, 0, 5'd0, 2'd0, 0));
    run_frame(fr(1, 0, 0, 0, 0, 5'd2, 2'd0, 0));

    // A reset pulse between edges is not sampled.
    reset = 1'b0;
    #3;
    reset = 1'b1;
    run_frame(fr(1, 0, 0, 0, 0, 5'd3, 2'd0, 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
